// File: rtl/i2s_rx_if.sv
// Three-wire I2S bus: bit clock, word select and serial data.
interface i2s;
    logic sclk;
    logic lrclk;
    logic sdi;

    modport rx (input sclk, input lrclk, input sdi);
    modport tx (output sclk, output lrclk, output sdi);
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: synchronises the bus into clk, deserialises L/R slots and emits one
// fifo write per complete left-then-right frame.
module i2s_rx #(
    parameter int DW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    i2s.rx                rx,
    output logic [DW-1:0] l_sample,
    output logic [DW-1:0] r_sample,
    output logic          wr_en,
    input  logic          wr_full,
    output logic          overflow,
    output logic          short_err,
    input  logic          err_clr
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    // one shared chain so sclk, lrclk and sdi keep their relative alignment
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        sclk_s, lr_s, sd_s, sclk_d;
    logic                        rise, lr_q, d_q, lr_prev, primed;
    logic [DW-1:0]               sh, sh_nx, l_hold;
    logic [CW-1:0]               cnt, cnt_nx;
    logic                        done, short_ev;
    state_t                      state;

    assign {sclk_s, lr_s, sd_s} = sync_q[SYNC_STAGES-1];

    always_comb begin
        sh_nx  = sh;
        cnt_nx = cnt;
        if (cnt < CW'(DW)) begin
            sh_nx  = sh | (DW'(d_q) << (CW'(DW - 1) - cnt));
            cnt_nx = cnt + CW'(1);
        end
    end

    // the bit sampled on a word-select flip is the LSB of the slot of lr_prev
    assign done     = rise & (lr_q != lr_prev);
    assign short_ev = done & primed & (state != SYNC) & (cnt_nx < CW'(DW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sclk_d    <= 1'b0;
            rise      <= 1'b0;
            lr_q      <= 1'b0;
            d_q       <= 1'b0;
            lr_prev   <= 1'b1;
            primed    <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
            l_hold    <= '0;
            l_sample  <= '0;
            r_sample  <= '0;
            wr_en     <= 1'b0;
            overflow  <= 1'b0;
            short_err <= 1'b0;
            state     <= SYNC;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx.sclk, rx.lrclk, rx.sdi};
            sclk_d <= sclk_s;
            rise   <= sclk_s & ~sclk_d;
            lr_q   <= lr_s;
            d_q    <= sd_s;
            wr_en  <= 1'b0;

            if (rise) begin
                lr_prev <= lr_q;
                primed  <= 1'b1;
                if (done) begin
                    sh  <= '0;
                    cnt <= '0;
                end else begin
                    sh  <= sh_nx;
                    cnt <= cnt_nx;
                end
                // the first rise after reset only seeds lr_prev: it cannot prove a slot boundary
                if (done && primed) begin
                    case (state)
                        SYNC:  if (lr_prev) state <= LEFT;
                        LEFT:  if (!lr_prev) begin
                                   l_hold <= sh_nx;
                                   state  <= RIGHT;
                               end
                        RIGHT: if (lr_prev) begin
                                   l_sample <= l_hold;
                                   r_sample <= sh_nx;
                                   wr_en    <= 1'b1;
                                   state    <= LEFT;
                               end
                        default: state <= SYNC;
                    endcase
                end
            end

            overflow  <= (overflow & ~err_clr) | (wr_en & wr_full);
            short_err <= (short_err & ~err_clr) | short_ev;
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// Randomised scoreboard bench for i2s_rx: slot-level model feeds an expected-frame queue,
// a monitor pops and compares on every wr_en.
module tb_i2s_rx;
    localparam int DW          = 24;
    localparam int SYNC_STAGES = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_full = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] l_sample, r_sample;
    logic          wr_en, overflow, short_err;

    i2s bus ();

    i2s_rx #(.DW(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus),
        .l_sample  (l_sample),
        .r_sample  (r_sample),
        .wr_en     (wr_en),
        .wr_full   (wr_full),
        .overflow  (overflow),
        .short_err (short_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int flip_cyc = 0;
    int fr_idx = 0;
    bit jit = 1'b0;
    bit prev_wr = 1'b0;

    bit                q_ch[$];
    bit                q_d[$];
    logic [2*DW-1:0]   exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: a slot keeps its first DW bits, missing LSBs read as zero
    function automatic logic [DW-1:0] capt(input int w, input logic [DW-1:0] word);
        logic [DW-1:0] mask;
        mask = '1;
        if (w >= DW) return word;
        mask = mask << (DW - w);
        return word & mask;
    endfunction

    task automatic add_slot(input bit ch, input int w, input logic [DW-1:0] word);
        for (int i = 0; i < w; i++) begin
            q_ch.push_back(ch);
            q_d.push_back(i < DW ? word[DW-1-i] : 1'($urandom()));
        end
    endtask

    // first frame after reset is lost to alignment; later ones are written
    task automatic add_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input int wl, input int wr);
        add_slot(1'b0, wl, l);
        add_slot(1'b1, wr, r);
        if (fr_idx >= 1) exp_q.push_back({capt(wl, l), capt(wr, r)});
        fr_idx++;
    endtask

    task automatic add_trailer();
        add_slot(1'b0, 4, DW'($urandom()));
    endtask

    function automatic int half();
        return jit ? 1 + int'($urandom_range(0, 2)) : 2;
    endfunction

    // word select leads data by one bit: lrclk shows the channel of the next bit
    task automatic emit(input int n);
        for (int i = 0; i < n && q_d.size() > 0; i++) begin
            bit c, d, lr;
            int lo, hi;
            c  = q_ch.pop_front();
            d  = q_d.pop_front();
            lr = (q_ch.size() > 0) ? q_ch[0] : c;
            lo = half();
            hi = half();
            @(negedge clk);
            bus.sclk = 1'b0; bus.lrclk = lr; bus.sdi = d;
            repeat (lo) @(negedge clk);
            bus.sclk = 1'b1;
            if (c && !lr) flip_cyc = cyc;
            repeat (hi - 1) @(negedge clk);
        end
    endtask

    task automatic emit_all();
        emit(q_d.size());
    endtask

    task automatic drain();
        repeat (30) @(negedge clk);
        chk("missing_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q_ch.delete(); q_d.delete(); exp_q.delete();
        fr_idx = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({wr_en, overflow, short_err, l_sample, r_sample}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    // monitor: scoreboard, latency from the R-LSB sclk rise, and single-cycle strobe
    always @(posedge clk) begin
        #1;
        if (prev_wr) chk("wr_en_width", 64'(wr_en), 64'd0);
        if (wr_en && !prev_wr) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", {16'd0, l_sample, r_sample}, 64'd0);
            end else begin
                logic [2*DW-1:0] e;
                e = exp_q.pop_front();
                chk("frame_data", 64'({l_sample, r_sample}), 64'(e));
            end
            chk("write_latency", 64'(cyc - flip_cyc), 64'(SYNC_STAGES + 2));
        end
        prev_wr = wr_en;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclk = 1'b0; bus.lrclk = 1'b0; bus.sdi = 1'b0;

        // fixed values, 32-bit slots
        do_reset();
        repeat (3) add_frame(24'hABCDEF, 24'h123456, 32, 32);
        add_trailer();
        emit_all();
        drain();
        chk("flags_clean", 64'({overflow, short_err}), 64'd0);

        // 16-bit slots: short words, flag clear and re-set
        do_reset();
        repeat (3) add_frame(24'hABCD00, 24'h800100, 16, 16);
        add_trailer();
        emit(33);
        repeat (10) @(negedge clk);
        chk("short_in_sync", 64'(short_err), 64'd0);
        emit(32);
        repeat (10) @(negedge clk);
        chk("short_set", 64'(short_err), 64'd1);
        pulse_clr();
        chk("short_cleared", 64'(short_err), 64'd0);
        emit_all();
        drain();
        chk("short_reset", 64'(short_err), 64'd1);

        // fifo full during writes
        do_reset();
        repeat (3) add_frame(DW'($urandom()), DW'($urandom()), 32, 32);
        add_trailer();
        chk("overflow_idle", 64'(overflow), 64'd0);
        wr_full = 1'b1;
        emit_all();
        @(negedge clk); wr_full = 1'b0;
        drain();
        chk("overflow_sticky", 64'(overflow), 64'd1);
        pulse_clr();
        chk("overflow_cleared", 64'(overflow), 64'd0);

        // reset mid R slot, released mid L slot
        do_reset();
        add_frame(DW'($urandom()), DW'($urandom()), 32, 32);
        add_frame(DW'($urandom()), DW'($urandom()), 32, 32);
        add_slot(1'b0, 32, DW'($urandom()));
        add_slot(1'b1, 32, DW'($urandom()));
        emit(64 + 64 + 32 + 16);
        repeat (10) @(negedge clk);
        chk("pre_reset_writes", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        q_ch.delete(); q_d.delete();
        fr_idx = 0;
        repeat (4) @(negedge clk);
        chk("outputs_in_reset", 64'({wr_en, overflow, short_err, l_sample, r_sample}), 64'd0);
        add_frame(DW'($urandom()), DW'($urandom()), 32, 32);
        add_frame(DW'($urandom()), DW'($urandom()), 32, 32);
        add_trailer();
        emit(10);
        @(negedge clk); rst = 1'b0;
        emit_all();
        drain();

        // random data, 24/32-bit slots, sclk jitter
        do_reset();
        jit = 1'b1;
        for (int f = 0; f < 250; f++)
            add_frame(DW'($urandom()), DW'($urandom()),
                      ($urandom_range(0, 1) != 0) ? 32 : 24,
                      ($urandom_range(0, 1) != 0) ? 32 : 24);
        add_trailer();
        emit_all();
        drain();
        chk("random_flags", 64'({overflow, short_err}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
